// File: rtl/shift_unit_if.sv
// Request/response bundle between a shift requester and shift_unit.
// The requester drives the operation fields and start; the unit returns result, busy and done.
interface shift_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output op,
        output data_in,
        output shamt,
        input  result,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  op,
        input  data_in,
        input  shamt,
        output result,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle barrel-less shifter: one bit position per clock, IDLE -> SHIFT -> DONE.
// Only WIDTH=32 is supported; the shift count is fixed at 5 bits.
module shift_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    shift_unit_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_s;
    logic [2:0]       op_r;
    logic [2:0]       op_s;
    logic [4:0]       count_r;
    logic [4:0]       count_s;
    logic             busy_r;
    logic             done_r;

    // Single-bit step of the selected operation; codes 101..111 leave the value untouched.
    function automatic logic [WIDTH-1:0] step_one(input logic [2:0] op_v,
                                                  input logic [WIDTH-1:0] r_v);
        logic [WIDTH-1:0] s_v;
        case (op_v)
            OP_SLL:  s_v = {r_v[WIDTH-2:0], 1'b0};
            OP_SRL:  s_v = {1'b0, r_v[WIDTH-1:1]};
            OP_SRA:  s_v = {r_v[WIDTH-1], r_v[WIDTH-1:1]};
            OP_ROR:  s_v = {r_v[0], r_v[WIDTH-1:1]};
            OP_ROL:  s_v = {r_v[WIDTH-2:0], r_v[WIDTH-1]};
            default: s_v = r_v;
        endcase
        return s_v;
    endfunction

    // Next-state and datapath update; start is only looked at while idle.
    always_comb begin
        state_s  = state_r;
        result_s = result_r;
        op_s     = op_r;
        count_s  = count_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    result_s = bus.data_in;
                    op_s     = bus.op;
                    count_s  = bus.shamt;
                    if (bus.shamt != 5'd0) begin
                        state_s = ST_SHIFT;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                result_s = step_one(op_r, result_r);
                count_s  = count_r - 5'd1;
                if (count_r == 5'd1) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                // Unreachable encoding: fall back to idle without producing a done pulse.
                state_s = ST_IDLE;
                count_s = 5'd0;
            end
        endcase
    end

    // State, operand and output registers; busy/done are registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            result_r <= {WIDTH{1'b0}};
            op_r     <= 3'b000;
            count_r  <= 5'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            result_r <= result_s;
            op_r     <= op_s;
            count_r  <= count_s;
            busy_r   <= (state_s != ST_IDLE);
            done_r   <= (state_s == ST_DONE);
        end
    end

    assign bus.result = result_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: vector table plus scoreboard queue,
// with hand-written sequences for ignored re-start and mid-operation reset.
module tb_shift_unit;

    logic clk;
    logic reset_n;

    shift_unit_if #(.WIDTH(32)) bus ();

    shift_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] exp_q[$];
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge with the unit idle; returns at a falling edge with it idle again.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] d,
                          input logic [4:0] s, input logic [31:0] e, input int repulse);
        int          cycles;
        int          busy_cnt;
        logic        got;
        logic [31:0] want;
        bus.start   = 1'b1;
        bus.op      = o;
        bus.data_in = d;
        bus.shamt   = s;
        exp_q.push_back(e);
        cycles   = 0;
        busy_cnt = 0;
        got      = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.start   = 1'b0;
                bus.data_in = $urandom();
                bus.op      = 3'($urandom_range(0, 7));
                bus.shamt   = 5'($urandom_range(0, 31));
            end
            if (repulse > 0 && i == repulse) begin
                bus.start   = 1'b1;
                bus.data_in = ~d;
                bus.op      = 3'b000;
                bus.shamt   = 5'd3;
            end
            if (repulse > 0 && i == repulse + 1) bus.start = 1'b0;
            cycles++;
            if (bus.busy) busy_cnt++;
            if (bus.done) got = 1'b1;
        end
        bus.start = 1'b0;
        chk({name, " done_seen"}, 32'(got), 32'd1);
        if (got) begin
            if (exp_q.size() == 0) begin
                chk({name, " scoreboard_nonempty"}, 32'd0, 32'd1);
            end else begin
                want = exp_q.pop_front();
                chk({name, " result"}, bus.result, want);
            end
        end
        chk({name, " latency"}, 32'(cycles), 32'(int'(s) + 1));
        chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(int'(s) + 1));
        @(negedge clk);
        chk({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({name, " idle_after"}, 32'(bus.busy), 32'd0);
        chk({name, " result_held"}, bus.result, e);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        checks = 0;
        errors = 0;

        vecs[0]  = '{3'd2, 32'h80000000, 5'd4,  32'hF8000000};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 5'd31, 32'h00000001};
        vecs[2]  = '{3'd4, 32'h80000001, 5'd1,  32'h00000003};
        vecs[3]  = '{3'd0, 32'h00000003, 5'd2,  32'h0000000C};
        vecs[4]  = '{3'd0, 32'h12345678, 5'd0,  32'h12345678};
        vecs[5]  = '{3'd3, 32'h12345678, 5'd0,  32'h12345678};
        vecs[6]  = '{3'd5, 32'h12345678, 5'd0,  32'h12345678};
        vecs[7]  = '{3'd7, 32'hDEADBEEF, 5'd9,  32'hDEADBEEF};
        vecs[8]  = '{3'd3, 32'h00000001, 5'd8,  32'h01000000};
        vecs[9]  = '{3'd4, 32'h12345678, 5'd4,  32'h23456781};
        vecs[10] = '{3'd3, 32'h12345678, 5'd4,  32'h81234567};
        vecs[11] = '{3'd2, 32'h7FFFFFFF, 5'd31, 32'h00000000};
        vecs[12] = '{3'd2, 32'hF0000000, 5'd31, 32'hFFFFFFFF};
        vecs[13] = '{3'd0, 32'hFFFFFFFF, 5'd31, 32'h80000000};
        vecs[14] = '{3'd1, 32'h80000000, 5'd1,  32'h40000000};
        vecs[15] = '{3'd4, 32'h80000000, 5'd31, 32'h40000000};

        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 3'b000;
        bus.data_in = 32'h0;
        bus.shamt   = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset result", bus.result, 32'h0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        reset_n = 1'b1;

        // Start ignored while idle stays idle for a cycle with start low.
        @(negedge clk);
        chk("idle hold busy", 32'(bus.busy), 32'd0);

        // Consecutive vectors are issued back-to-back, the cycle after each done.
        for (int v = 0; v < 16; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].data, vecs[v].shamt, vecs[v].exp, 0);
        end

        // Re-pulse start with different operands mid-operation: must be ignored.
        run_op("repulse", 3'd3, 32'h00000001, 5'd8, 32'h01000000, 3);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("repulse no_queued_op", 32'(seen), 32'd0);

        // Reset in the middle of an SLL by 16, five shift cycles in.
        bus.start   = 1'b1;
        bus.op      = 3'b000;
        bus.data_in = 32'h00000001;
        bus.shamt   = 5'd16;
        exp_q.push_back(32'h00010000);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset pre busy", 32'(bus.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset result", bus.result, 32'h0);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset done", 32'(bus.done), 32'd0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("midreset no_done", 32'(seen), 32'd0);
        chk("midreset result_after", bus.result, 32'h0);

        // First operation after reset release still works normally.
        run_op("post_reset", 3'd1, 32'h00000100, 5'd4, 32'h00000010, 0);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
